// File: rtl/axis_pfbsynth_feeder_pkg.sv
// Shared constants and types for the synthesis-PFB frame feeder.
// Optional channel masking is enabled by defining AXIS_PFBSYNTH_FEEDER_MASK_EN.
package axis_pfbsynth_feeder_pkg;

    localparam int N_CH  = 64;
    localparam int LANES = 8;
    localparam int DW    = 32;
    localparam int BEATS = N_CH / LANES;
    localparam int CHW   = $clog2(N_CH);

    typedef logic [DW-1:0]              sample_t;
    typedef logic [$clog2(BEATS)-1:0]   beat_t;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/pfb_feeder_bank.sv
// Double-buffered channel store: random-access shadow writes, atomic commit to
// the active bank, and an L-lane read port. Masking under AXIS_PFBSYNTH_FEEDER_MASK_EN.
module pfb_feeder_bank
    import axis_pfbsynth_feeder_pkg::*;
#(
    parameter int N = N_CH,
    parameter int L = LANES,
    localparam int CW = $clog2(N),
    localparam int LW = $clog2(L),
    localparam int BW = $clog2(N / L)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_wr_en,
    input  logic [CW-1:0]   i_wr_addr,
    input  sample_t         i_wr_data,
    input  logic            i_commit,
    input  logic [BW-1:0]   i_beat,
`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
    input  logic [N-1:0]    i_ch_en,
`endif
    output logic [L*DW-1:0] o_lanes
);

    sample_t r_shadow [N];
    sample_t r_active [N];

    // Commit and write never coincide (the top blocks writes while a commit
    // is pending), so the copy always sees a settled shadow bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (i_wr_en)
                r_shadow[i_wr_addr] <= i_wr_data;
            if (i_commit)
                r_active <= r_shadow;
        end
    end

`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
    logic [N-1:0] r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mask <= '1;
        else if (i_commit)
            r_mask <= i_ch_en;
    end
`endif

    for (genvar k = 0; k < L; k++) begin : g_lane
        logic [CW-1:0] w_idx;
        assign w_idx = {i_beat, LW'(k)};
`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
        assign o_lanes[k*DW +: DW] = r_mask[w_idx] ? r_active[w_idx] : '0;
`else
        assign o_lanes[k*DW +: DW] = r_active[w_idx];
`endif
    end

endmodule

// File: rtl/axis_pfbsynth_feeder.sv
// Continuous N/L-beat frame transmitter with frame-boundary commit of channel updates.
// Define AXIS_PFBSYNTH_FEEDER_MASK_EN to add the ch_en per-channel output mask.
module axis_pfbsynth_feeder
    import axis_pfbsynth_feeder_pkg::*;
#(
    parameter int N = N_CH,
    parameter int L = LANES
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DW-1:0]         s_axis_tdata,
    input  logic [$clog2(N)-1:0]  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [L*DW-1:0]       m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
    input  logic [N-1:0]          ch_en,
`endif
    input  logic                  m_axis_tready
);

    localparam int NB = N / L;
    localparam int BW = $clog2(NB);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_m_valid;
    logic [BW-1:0] r_beat;
    logic          r_pending;
    logic          w_s_fire;
    logic          w_m_fire;
    logic          w_last_beat;
    logic          w_commit;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_state <= ST_RESET;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_valid   = 1'b0;
        case (r_state)
            ST_RESET: w_state_nxt = ST_RUN;
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                w_m_valid   = 1'b1;
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    assign w_s_fire    = s_axis_tvalid & ~r_pending;
    assign w_m_fire    = w_m_valid & m_axis_tready;
    assign w_last_beat = (r_beat == BW'(NB - 1));
    assign w_commit    = w_m_fire & w_last_beat & r_pending;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_beat <= '0;
        else if (w_m_fire)
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
    end

    // A tlast write landing in a boundary cycle with nothing pending only
    // arms the flag; the commit then waits a full frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_pending <= 1'b0;
        else if (w_commit)
            r_pending <= 1'b0;
        else if (w_s_fire && s_axis_tlast)
            r_pending <= 1'b1;
    end

    pfb_feeder_bank #(
        .N (N),
        .L (L)
    ) u_bank (
        .clk       (aclk),
        .rst_n     (aresetn),
        .i_wr_en   (w_s_fire),
        .i_wr_addr (s_axis_tuser),
        .i_wr_data (s_axis_tdata),
        .i_commit  (w_commit),
        .i_beat    (r_beat),
`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
        .i_ch_en   (ch_en),
`endif
        .o_lanes   (m_axis_tdata)
    );

    assign s_axis_tready = ~r_pending;
    assign m_axis_tvalid = w_m_valid;
    assign m_axis_tlast  = w_last_beat;

endmodule

// File: tb/tb_axis_pfbsynth_feeder.sv
// Directed bench for axis_pfbsynth_feeder: vector table for the first frames,
// then hand sequences for stalls, overwrite, mid-frame reset and (optionally) masking.
module tb_axis_pfbsynth_feeder;
    import axis_pfbsynth_feeder_pkg::*;

    localparam int N = 64;
    localparam int L = 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [31:0]       s_axis_tdata;
    logic [5:0]        s_axis_tuser;
    logic              s_axis_tlast;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [L*32-1:0]   m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
    logic [N-1:0]      ch_en;
`endif

    always #5 aclk = ~aclk;

    axis_pfbsynth_feeder #(.N(N), .L(L)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
        .ch_en         (ch_en),
`endif
        .m_axis_tready (m_axis_tready)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wv;
        logic [5:0]  ch;
        logic [31:0] wd;
        logic        wl;
        logic        mrdy;
        logic        e_srdy;
        logic        e_mvld;
        logic        e_last;
        int          lane;
        logic [31:0] e_lane;
    } vec_t;

    vec_t vt [24];

    // Reference state for the sequence phase
    logic [31:0]  m_shadow [N];
    logic [31:0]  m_active [N];
    logic [N-1:0] m_mask;
    logic         m_pend;
    int           m_beat;
    logic [255:0] prev_td;
    logic         prev_stall;

    function automatic logic [255:0] exp_data(input int b);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < L; k++)
            r[k*32 +: 32] = m_mask[b*L+k] ? m_active[b*L+k] : 32'h0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_mask     = '1;
        m_pend     = 1'b0;
        m_beat     = 0;
        prev_stall = 1'b0;
    endtask

    task automatic run_cycle(input logic wv, input logic [5:0] ch, input logic [31:0] wd,
                             input logic wl, input logic mrdy);
        logic commit, fire;
        s_axis_tvalid = wv;
        s_axis_tuser  = ch;
        s_axis_tdata  = wd;
        s_axis_tlast  = wl;
        m_axis_tready = mrdy;
        @(negedge aclk);
        chk("seq_tvalid", m_axis_tvalid, 1'b1);
        chk("seq_s_tready", s_axis_tready, !m_pend);
        chk("seq_tlast", m_axis_tlast, m_beat == L - 1);
        chk("seq_tdata", m_axis_tdata, exp_data(m_beat));
        if (prev_stall) chk("hold_tdata", m_axis_tdata, prev_td);
        prev_td    = m_axis_tdata;
        prev_stall = !mrdy;
        @(posedge aclk);
        #1;
        commit = mrdy && (m_beat == L - 1) && m_pend;
        fire   = wv && !m_pend;
        if (fire) m_shadow[ch] = wd;
        if (commit) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
            m_mask   = ch_en;
`endif
        end
        if (fire && wl) m_pend = 1'b1;
        if (mrdy) m_beat = (m_beat + 1) % (N / L);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, s_axis_tready, 1'b1);
        chk({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
        chk({tag, "_m_tlast"},  m_axis_tlast,  1'b0);
        chk({tag, "_m_tdata"},  m_axis_tdata,  '0);
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
        ch_en = '1;
`endif

        // Frames 0-2: two writes during frame 1, commit at its last beat
        for (int c = 0; c < 24; c++) begin
            vt[c] = '{wv: 1'b0, ch: 6'd0, wd: 32'h0, wl: 1'b0, mrdy: 1'b1,
                      e_srdy: 1'b1, e_mvld: 1'b1, e_last: (c % 8 == 7),
                      lane: c % 8, e_lane: 32'h0};
        end
        vt[10].wv = 1'b1; vt[10].ch = 6'd0;  vt[10].wd = 32'h0001_0002;
        vt[11].wv = 1'b1; vt[11].ch = 6'd63; vt[11].wd = 32'hFFFF_8000; vt[11].wl = 1'b1;
        for (int c = 12; c < 16; c++) vt[c].e_srdy = 1'b0;
        vt[16].lane = 0; vt[16].e_lane = 32'h0001_0002;
        vt[23].lane = 7; vt[23].e_lane = 32'hFFFF_8000;

        #2;
        @(negedge aclk);
        check_reset_outputs("reset");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        for (int c = 0; c < 24; c++) begin
            s_axis_tvalid = vt[c].wv;
            s_axis_tuser  = vt[c].ch;
            s_axis_tdata  = vt[c].wd;
            s_axis_tlast  = vt[c].wl;
            m_axis_tready = vt[c].mrdy;
            @(negedge aclk);
            chk($sformatf("v%0d_s_tready", c), s_axis_tready, vt[c].e_srdy);
            chk($sformatf("v%0d_m_tvalid", c), m_axis_tvalid, vt[c].e_mvld);
            chk($sformatf("v%0d_m_tlast", c),  m_axis_tlast,  vt[c].e_last);
            chk($sformatf("v%0d_lane%0d", c, vt[c].lane),
                m_axis_tdata[vt[c].lane*32 +: 32], vt[c].e_lane);
            @(posedge aclk);
            #1;
        end

        model_reset();
        m_shadow[0]  = 32'h0001_0002;  m_active[0]  = 32'h0001_0002;
        m_shadow[63] = 32'hFFFF_8000;  m_active[63] = 32'hFFFF_8000;

        // Overwrite ch5, then random stalls while the commit is pending
        run_cycle(1'b1, 6'd5, 32'hA, 1'b0, 1'b1);
        run_cycle(1'b1, 6'd5, 32'hB, 1'b1, 1'b1);
        for (int i = 0; i < 100 && m_pend; i++)
            run_cycle(1'b0, 6'd0, 32'h0, 1'b0, 1'($urandom_range(0, 1)));
        chk("commit_done", s_axis_tready, 1'b1);
        for (int i = 0; i < 16; i++)
            run_cycle(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8 && m_beat != 0; i++)
            run_cycle(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
        @(negedge aclk);
        chk("ch5_last_write", m_axis_tdata[5*32 +: 32], 32'hB);
        @(posedge aclk);
        #1;
        m_beat = (m_beat + 1) % (N / L);
        prev_stall = 1'b0;

        // Pending commit interrupted by reset on beat 3
        for (int i = 0; i < 8 && m_beat != 1; i++)
            run_cycle(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
        run_cycle(1'b1, 6'd1, 32'h1234, 1'b1, 1'b1);
        run_cycle(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
        s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        @(negedge aclk);
        check_reset_outputs("midreset");
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
        @(posedge aclk);
        #1;
        for (int i = 0; i < 16; i++)
            run_cycle(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);

`ifdef AXIS_PFBSYNTH_FEEDER_MASK_EN
        ch_en = ~(64'h1 << 9);
        run_cycle(1'b1, 6'd9, 32'h99, 1'b0, 1'b1);
        run_cycle(1'b1, 6'd8, 32'h88, 1'b1, 1'b1);
        for (int i = 0; i < 20 && m_pend; i++)
            run_cycle(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            run_cycle(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8 && m_beat != 1; i++)
            run_cycle(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
        @(negedge aclk);
        chk("mask_ch9", m_axis_tdata[1*32 +: 32], 32'h0);
        chk("mask_ch8", m_axis_tdata[0*32 +: 32], 32'h88);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_pfbsynth_feeder.md
# axis_pfbsynth_feeder

Channel-frame transmitter feeding the 8-lane, 64-channel input stream of the synthesis polyphase filter bank. It holds one 32-bit complex sample (16-bit I low, 16-bit Q high) per channel in a double-buffered bank. Random-order, channel-addressed updates are written into a shadow bank and committed atomically at a frame boundary. It emits continuous frames of N/L beats, with tlast marking the final beat of each frame.

## Interface
- N, 64, number of channels; power of two, multiple of L
- L, 8, lanes per output beat (32 bits each)
- aclk  in  1  single clock for all ports
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  32  channel sample {Q[15:0], I[15:0]}
- s_axis_tuser  in  log2(N)  target channel index
- s_axis_tlast  in  1  closes the current update set and requests a commit
- s_axis_tvalid  in  1  write valid
- s_axis_tready  out  1  write ready
- m_axis_tdata  out  L*32  lane k = channel b*L+k on beat b
- m_axis_tlast  out  1  high on beat N/L-1
- m_axis_tvalid  out  1  frame data valid
- m_axis_tready  in  1  downstream ready

## Operation
- Storage: shadow[N] and active[N], 32 bits each; both are all-zero after reset.
- Write: when s_axis_tvalid && s_axis_tready, set shadow[tuser] <= tdata. Later writes to the same channel overwrite earlier ones.
- Commit request: when a write with s_axis_tlast=1 is accepted, set pending <= 1. That write's data is part of the set being committed.
- s_axis_tready = ~pending. No writes are accepted while a commit is waiting, so update sets never mix.
- Beat counter beat (0..N/L-1) advances on m_axis_tvalid && m_axis_tready and wraps to 0 after N/L-1.
- Frame boundary: the cycle in which beat N/L-1 transfers. If pending=1 in that cycle:
  - active <= shadow, including every write accepted up to the previous cycle.
  - pending <= 0.
- If pending=0 at the boundary, active is unchanged and the same frame repeats.
- m_axis_tdata: combinational lane mux of active[beat*L +: L]. m_axis_tlast = (beat == N/L-1).
- Output state machine:
  - RESET: m_axis_tvalid=0.
  - RUN: m_axis_tvalid=1, entered on the first aclk edge after aresetn deasserts.
  - There is no idle state. The frame stream is continuous and backpressure only stalls beat.
- Backpressure: while m_axis_tready=0, beat, tdata and tlast hold. A commit cannot happen mid-frame.

## Timing
- Reset values:
  - s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - beat=0, pending=0, both banks zero.
- Reset is honoured at any point, including mid-frame or with a commit pending. Everything returns to reset values and no partial frame resumes.
- Write-to-output latency: tlast accepted at cycle t. The data appears on beat 0 of the first frame that starts after the next boundary with t' > t. With continuous tready this is at most N/L+1 cycles.
- Boundary cycle with a concurrent s_axis transfer: impossible, because pending=1 forces tready=0.
- tlast write accepted in the boundary cycle itself: pending sets in that cycle, and the commit waits for the following boundary.
- s_axis_tready rises the cycle after the commit.

## Configuration
- AXIS_PFBSYNTH_FEEDER_MASK_EN defined:
  - Adds input ch_en [N-1:0] and an active-mask register, all-ones at reset.
  - ch_en is sampled into the mask at commit, together with the data.
  - Lanes of channels whose mask bit is 0 output 32'h0.
- Not defined: the ch_en port and mask do not exist, and all channels pass unmodified.

## Structure
- Package axis_pfbsynth_feeder_pkg holds:
  - Constants: DW=32, BEATS=N/L, CHW=$clog2(N).
  - typedef sample_t (logic [31:0]).
  - typedef beat_t (logic [$clog2(BEATS)-1:0]).
- One sub-module, pfb_feeder_bank: the shadow/active storage with write port, commit strobe and L-lane beat read port. The top holds the handshake, pending flag and beat counter.

## Test plan
- Reset release, no writes, tready=1 -> tvalid=1 from the 1st cycle, all-zero data, tlast on every 8th beat (beats 7, 15, ...).
- Write ch0=32'h0001_0002 and ch63=32'hFFFF_8000 (tlast on the 2nd write) mid-frame -> tready=0 until the boundary. The next beat 0 shows lane 0=32'h0001_0002, and beat 7 shows lane 7=32'hFFFF_8000.
- Toggle m_axis_tready randomly during a pending commit -> the commit occurs only on the beat-7 transfer, and the data and tlast hold stable while stalled.
- Write ch5 twice (32'hA, then 32'hB with tlast) -> after commit, beat 0 lane 5=32'hB. Frames repeat unchanged until the next commit.
- Assert aresetn=0 on beat 3 with pending=1 -> all outputs return to reset values. After release, frames are all-zero and tready=1.
- With MASK_EN: commit with ch_en=~64'h0 except bit 9 -> beat 1 lane 1=0. Other channels carry their written data.
